led_scan_bcd_display: RTL and testbench

- Parametrised multiplexed 7-segment driver; successor to the 4-digit nixie/LED scanner.
- Converts an unsigned binary value to BCD using a sequential shift-add-3 (double-dabble) engine, then scans DIGITS common-cathode-style positions.
- Adds leading-zero blanking, per-digit decimal points, an overflow indication and a conversion-done strobe.
- Sits between datapath status registers and the board LED module pins.

---
 rtl/led_scan_bcd_display_if.sv | 33 +++
 rtl/led_scan_bcd_display.sv | 235 +++++++++++++++++++++++
 tb/tb_led_scan_bcd_display.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/led_scan_bcd_display_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_scan_bcd_display_if
//  Description : Display bus between a datapath status block and the
//                multiplexed 7-segment scanner.
//                master : drives EN, LZB, DP, Data_Bin; observes the outputs
//                slave  : the scanner; consumes the inputs, drives
//                         Conv_Done, COM, SEG
//  Revision    : 1.0  initial release
// ============================================================================
interface led_scan_bcd_display_if #(
    parameter int DATA_W = 14,
    parameter int DIGITS = 4
);
    logic              EN;
    logic              LZB;
    logic [DIGITS-1:0] DP;
    logic [DATA_W-1:0] Data_Bin;
    logic              Conv_Done;
    logic [DIGITS-1:0] COM;
    logic [7:0]        SEG;

    modport master (
        output EN, LZB, DP, Data_Bin,
        input  Conv_Done, COM, SEG
    );

    modport slave (
        input  EN, LZB, DP, Data_Bin,
        output Conv_Done, COM, SEG
    );
endinterface
`default_nettype wire

// File: rtl/led_scan_bcd_display.sv
`default_nettype none
// ============================================================================
//  Module      : led_scan_bcd_display
//  Description : Multiplexed 7-segment driver. A sequential double-dabble
//                engine converts Data_Bin to BCD every DATA_W+2 clocks; the
//                result is latched into a display register and scanned across
//                DIGITS active-low digit selects, with leading-zero blanking,
//                per-digit decimal points and an overflow dash pattern.
//  Ports       : Sys_CLK        system clock, rising edge
//                Sys_RST        synchronous active-high reset
//                bus.EN         display enable (0 blanks COM/SEG)
//                bus.LZB        leading-zero blanking enable
//                bus.DP         decimal point per digit
//                bus.Data_Bin   unsigned value to display
//                bus.Conv_Done  one-cycle pulse on display register update
//                bus.COM        active-low one-hot digit select
//                bus.SEG        segments {a,b,c,d,e,f,g,dp}, active-high
//  Revision    : 1.0  initial release
// ============================================================================
module led_scan_bcd_display #(
    parameter int DATA_W = 14,
    parameter int DIGITS = 4,
    parameter int DIV    = 5000
) (
    input  wire logic                 Sys_CLK,
    input  wire logic                 Sys_RST,
    led_scan_bcd_display_if.slave     bus
);

    // Number of BCD nibbles needed for 2^DATA_W-1, never fewer than DIGITS.
    function automatic int f_nibbles(input int w, input int d);
        logic [63:0] v;
        int          n;
        v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (v != 64'd0) begin
                v = v / 64'd10;
                n = n + 1;
            end
        end
        if (n < d) n = d;
        return n;
    endfunction

    function automatic logic [7:0] f_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hFC;
            4'd1:    s = 8'h60;
            4'd2:    s = 8'hDA;
            4'd3:    s = 8'hF2;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'hB6;
            4'd6:    s = 8'hBE;
            4'd7:    s = 8'hE0;
            4'd8:    s = 8'hFE;
            4'd9:    s = 8'hF6;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    localparam int c_NIB   = f_nibbles(DATA_W, DIGITS);
    localparam int c_BCD_W = c_NIB * 4;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_PRE_W = $clog2(DIV);
    localparam int c_CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Scan prescaler and digit index
    // ------------------------------------------------------------------
    logic [c_PRE_W-1:0] r_presc;
    logic [c_IDX_W-1:0] r_idx;
    logic               w_tick;

    assign w_tick = (r_presc == c_PRE_W'(DIV - 1));

    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_PRE_W'(1);
            if (w_tick) begin
                r_idx <= (r_idx == c_IDX_W'(DIGITS - 1)) ? '0 : r_idx + c_IDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Converter FSM
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_shift;
    logic               w_done;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load      = 1'b1;
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == c_CNT_W'(1)) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Double-dabble datapath
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   r_bin;
    logic [c_BCD_W-1:0]  r_bcd;
    logic [c_BCD_W-1:0]  w_adj;
    logic [DIGITS*4-1:0] r_disp;
    logic                r_ovf;
    logic                r_conv_done;
    logic                w_ovf;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < c_NIB; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

    // Any nonzero nibble above the displayed ones means value >= 10^DIGITS.
    generate
        if (c_NIB > DIGITS) begin : g_ovf
            assign w_ovf = |r_bcd[c_BCD_W-1:DIGITS*4];
        end else begin : g_no_ovf
            assign w_ovf = 1'b0;
        end
    endgenerate

    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            r_bin       <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_disp      <= '0;
            r_ovf       <= 1'b0;
            r_conv_done <= 1'b0;
        end else begin
            r_conv_done <= w_done;
            if (w_load) begin
                r_bin <= bus.Data_Bin;
                r_bcd <= '0;
                r_cnt <= c_CNT_W'(DATA_W);
            end else if (w_shift) begin
                r_bcd <= {w_adj[c_BCD_W-2:0], r_bin[DATA_W-1]};
                r_bin <= r_bin << 1;
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
            if (w_done) begin
                r_disp <= r_bcd[DIGITS*4-1:0];
                r_ovf  <= w_ovf;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage: COM/SEG are registered from the current index and the
    // display register, so a display update lands whole on the next edge.
    // ------------------------------------------------------------------
    logic [3:0]        w_dig;
    logic              w_dp;
    logic              w_hi_zero;
    logic [7:0]        w_seg;
    logic [DIGITS-1:0] w_com;
    logic [DIGITS-1:0] r_com;
    logic [7:0]        r_seg;

    always_comb begin
        w_dig     = 4'd0;
        w_dp      = 1'b0;
        w_hi_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c_IDX_W'(i) == r_idx) begin
                w_dig = r_disp[i*4 +: 4];
                w_dp  = bus.DP[i];
            end
            // Current digit and everything above it must be zero to blank.
            if ((c_IDX_W'(i) >= r_idx) && (r_disp[i*4 +: 4] != 4'd0)) w_hi_zero = 1'b0;
        end
    end

    always_comb begin
        w_com = ~(DIGITS'(1) << r_idx);
        if (r_ovf)                                        w_seg = 8'h02 | {7'd0, w_dp};
        else if (bus.LZB && (r_idx != '0) && w_hi_zero)   w_seg = {7'd0, w_dp};
        else                                              w_seg = f_decode(w_dig) | {7'd0, w_dp};
    end

    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST || !bus.EN) begin
            r_com <= '1;
            r_seg <= 8'h00;
        end else begin
            r_com <= w_com;
            r_seg <= w_seg;
        end
    end

    assign bus.COM       = r_com;
    assign bus.SEG       = r_seg;
    assign bus.Conv_Done = r_conv_done;

endmodule
`default_nettype wire

// File: tb/tb_led_scan_bcd_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_scan_bcd_display
//  Description : Self-checking bench for led_scan_bcd_display (DATA_W=14,
//                DIGITS=4, DIV=4). Table of {value, LZB, DP, expected SEG per
//                digit} plus directed reset, input-stability and enable
//                sequences. A free-running cycle count since reset release
//                predicts the scan index and Conv_Done timing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_scan_bcd_display;

    localparam int DATA_W = 14;
    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int PERIOD = DATA_W + 2;

    logic Sys_CLK = 1'b0;
    logic Sys_RST = 1'b1;
    always #5 Sys_CLK = ~Sys_CLK;

    led_scan_bcd_display_if #(.DATA_W(DATA_W), .DIGITS(DIGITS)) bus ();

    led_scan_bcd_display #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS),
        .DIV    (DIV)
    ) dut (
        .Sys_CLK (Sys_CLK),
        .Sys_RST (Sys_RST),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;   // rising edges since reset release

    always @(posedge Sys_CLK) begin
        if (Sys_RST) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    typedef struct {
        logic [13:0]      data;
        logic             lzb;
        logic [3:0]       dp;
        logic [3:0][7:0]  seg;   // seg[i] = expected SEG of digit i
    } vec_t;

    vec_t vt [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    // Outputs sampled after edge n show the index held after edge n-1.
    function automatic int exp_idx(input int c);
        return ((c - 1) / DIV) % DIGITS;
    endfunction

    function automatic logic [3:0] exp_com(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << exp_idx(c));
    endfunction

    task automatic wait_done();
        bit found;
        int k;
        found = 1'b0;
        k     = 0;
        while (!found && k < 64) begin
            @(negedge Sys_CLK);
            k = k + 1;
            if (bus.Conv_Done === 1'b1) found = 1'b1;
        end
        check("conv_done_seen", {31'd0, found}, 32'd1);
    endtask

    // Called at a Conv_Done sample; covers exactly the 16 output cycles
    // driven from the display register just updated (one full frame).
    task automatic frame(input logic [3:0][7:0] exp, input string tag);
        int ei;
        for (int s = 0; s < 16; s++) begin
            @(negedge Sys_CLK);
            ei = exp_idx(cyc);
            check({tag, "_com"},  {28'd0, bus.COM}, {28'd0, exp_com(cyc)});
            check({tag, "_seg"},  {24'd0, bus.SEG}, {24'd0, exp[ei]});
            check({tag, "_done"}, {31'd0, bus.Conv_Done}, {31'd0, ((cyc % PERIOD) == 0)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit got;
        logic [3:0][7:0] e1234;
        logic [3:0][7:0] e5678;

        e1234 = {8'h60, 8'hDA, 8'hF2, 8'h66};
        e5678 = {8'hB6, 8'hBE, 8'hE0, 8'hFE};

        vt[0]  = '{14'd1234,  1'b0, 4'b0000, {8'h60, 8'hDA, 8'hF2, 8'h66}};
        vt[1]  = '{14'd7,     1'b1, 4'b0010, {8'h00, 8'h00, 8'h01, 8'hE0}};
        vt[2]  = '{14'd7,     1'b0, 4'b0010, {8'hFC, 8'hFC, 8'hFD, 8'hE0}};
        vt[3]  = '{14'd0,     1'b1, 4'b0000, {8'h00, 8'h00, 8'h00, 8'hFC}};
        vt[4]  = '{14'd12000, 1'b0, 4'b0000, {8'h02, 8'h02, 8'h02, 8'h02}};
        vt[5]  = '{14'd9999,  1'b0, 4'b0000, {8'hF6, 8'hF6, 8'hF6, 8'hF6}};
        vt[6]  = '{14'd5678,  1'b0, 4'b0000, {8'hB6, 8'hBE, 8'hE0, 8'hFE}};
        vt[7]  = '{14'd1000,  1'b1, 4'b0000, {8'h60, 8'hFC, 8'hFC, 8'hFC}};
        vt[8]  = '{14'd50,    1'b1, 4'b0001, {8'h00, 8'h00, 8'hB6, 8'hFD}};
        vt[9]  = '{14'd10000, 1'b1, 4'b1000, {8'h03, 8'h02, 8'h02, 8'h02}};
        vt[10] = '{14'd16383, 1'b0, 4'b0000, {8'h02, 8'h02, 8'h02, 8'h02}};
        vt[11] = '{14'd9,     1'b1, 4'b0000, {8'h00, 8'h00, 8'h00, 8'hF6}};
        vt[12] = '{14'd305,   1'b1, 4'b0100, {8'h00, 8'hF3, 8'hFC, 8'hB6}};

        bus.EN       = 1'b1;
        bus.LZB      = 1'b0;
        bus.DP       = 4'b0000;
        bus.Data_Bin = 14'd1234;

        // Power-on reset
        Sys_RST = 1'b1;
        repeat (3) @(negedge Sys_CLK);
        check("por_com",  {28'd0, bus.COM}, 32'hF);
        check("por_seg",  {24'd0, bus.SEG}, 32'h0);
        check("por_done", {31'd0, bus.Conv_Done}, 32'd0);
        Sys_RST = 1'b0;

        // Reset mid-scan (index 1) and mid-SHIFT
        wait_done();
        repeat (5) @(negedge Sys_CLK);
        Sys_RST = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(negedge Sys_CLK);
            check("rst_com",  {28'd0, bus.COM}, 32'hF);
            check("rst_seg",  {24'd0, bus.SEG}, 32'h0);
            check("rst_done", {31'd0, bus.Conv_Done}, 32'd0);
        end
        Sys_RST = 1'b0;

        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge Sys_CLK);
            n = n + 1;
            if (n <= 5) check("post_rst_com", {28'd0, bus.COM}, {28'd0, exp_com(cyc)});
            if (bus.Conv_Done === 1'b1) got = 1'b1;
        end
        check("first_done_latency", n, 32'd16);

        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge Sys_CLK);
            n = n + 1;
            if (bus.Conv_Done === 1'b1) got = 1'b1;
        end
        check("done_period", n, 32'd16);

        // Table-driven conversion / decode / blanking / overflow
        for (int v = 0; v < 13; v++) begin
            bus.Data_Bin = vt[v].data;
            bus.LZB      = vt[v].lzb;
            bus.DP       = vt[v].dp;
            wait_done();
            wait_done();
            frame(vt[v].seg, $sformatf("vec%0d", v));
        end

        // Data_Bin changed mid-SHIFT is not seen until the next capture
        bus.Data_Bin = 14'd1234;
        bus.LZB      = 1'b0;
        bus.DP       = 4'b0000;
        @(posedge Sys_CLK);              // IDLE capture of 1234
        repeat (3) @(posedge Sys_CLK);
        @(negedge Sys_CLK);
        bus.Data_Bin = 14'd5678;
        wait_done();
        frame(e1234, "stab_old");
        frame(e5678, "stab_new");

        // Enable gating
        bus.EN = 1'b0;
        for (int e = 0; e < 10; e++) begin
            @(negedge Sys_CLK);
            check("en_off_com", {28'd0, bus.COM}, 32'hF);
            check("en_off_seg", {24'd0, bus.SEG}, 32'h0);
        end
        bus.EN = 1'b1;
        @(negedge Sys_CLK);
        check("en_on_com", {28'd0, bus.COM}, {28'd0, exp_com(cyc)});
        check("en_on_seg", {24'd0, bus.SEG}, {24'd0, e5678[exp_idx(cyc)]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
